// File: rtl/board_input_conditioner.sv
// Board input conditioner: synchronizes and debounces switches and pushbuttons,
// then turns debounced button presses into Run/stop control and switch-load capture.
module board_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  sw_raw,
  input  logic        run_btn_raw,
  input  logic        stop_btn_raw,
  input  logic        load_btn_raw,
  output logic [31:0] device_data,
  output logic        Run,
  output logic        stop,
  output logic        load_strobe
);

  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);
  localparam int BTN_RUN  = 0;
  localparam int BTN_STOP = 1;
  localparam int BTN_LOAD = 2;

  logic [2:0]       btn_raw;
  logic [2:0]       btn_meta_q, btn_sync_q;
  logic [2:0]       btn_stable_q, btn_stable_d;
  logic [2:0]       btn_prev_q;
  logic [2:0][15:0] btn_cnt_q, btn_cnt_d;
  logic [2:0]       btn_rise;

  logic [7:0]       sw_meta_q, sw_sync_q, sw_last_q;
  logic [7:0]       sw_stable_q, sw_stable_d;
  logic [15:0]      sw_cnt_q, sw_cnt_d;

  logic             run_q, run_d;
  logic             stop_q, stop_d;
  logic             load_q, load_d;
  logic [31:0]      data_q, data_d;

  assign btn_raw = {load_btn_raw, stop_btn_raw, run_btn_raw};

  // Per-button debounce: the stable bit only follows the synced bit after it
  // has disagreed for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    btn_stable_d = btn_stable_q;
    btn_cnt_d    = '0;
    for (int i = 0; i < 3; i++) begin
      if (btn_sync_q[i] != btn_stable_q[i]) begin
        if (btn_cnt_q[i] == CNT_MAX) begin
          btn_stable_d[i] = btn_sync_q[i];
        end else begin
          btn_cnt_d[i] = btn_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // Switch group debounce: any movement of the synced vector restarts the count,
  // so only a vector that sits still for the full window is accepted.
  always_comb begin
    sw_stable_d = sw_stable_q;
    sw_cnt_d    = '0;
    if ((sw_sync_q != sw_stable_q) && (sw_sync_q == sw_last_q)) begin
      if (sw_cnt_q == CNT_MAX) begin
        sw_stable_d = sw_sync_q;
      end else begin
        sw_cnt_d = sw_cnt_q + 16'd1;
      end
    end
  end

  assign btn_rise = btn_stable_q & ~btn_prev_q;

  // Load captures the switch vector as it stood before any same-cycle update.
  always_comb begin
    stop_d = btn_rise[BTN_STOP];
    load_d = btn_rise[BTN_LOAD];
    data_d = data_q;
    run_d  = run_q;
    if (btn_rise[BTN_LOAD]) begin
      data_d = {24'b0, sw_stable_q};
    end
    if (btn_rise[BTN_STOP]) begin
      run_d = 1'b0;
    end else if (btn_rise[BTN_RUN]) begin
      run_d = ~run_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_meta_q   <= '0;
      btn_sync_q   <= '0;
      btn_stable_q <= '0;
      btn_prev_q   <= '0;
      btn_cnt_q    <= '0;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      sw_last_q    <= '0;
      sw_stable_q  <= '0;
      sw_cnt_q     <= '0;
      run_q        <= 1'b0;
      stop_q       <= 1'b0;
      load_q       <= 1'b0;
      data_q       <= '0;
    end else begin
      btn_meta_q   <= btn_raw;
      btn_sync_q   <= btn_meta_q;
      btn_stable_q <= btn_stable_d;
      btn_prev_q   <= btn_stable_q;
      btn_cnt_q    <= btn_cnt_d;
      sw_meta_q    <= sw_raw;
      sw_sync_q    <= sw_meta_q;
      sw_last_q    <= sw_sync_q;
      sw_stable_q  <= sw_stable_d;
      sw_cnt_q     <= sw_cnt_d;
      run_q        <= run_d;
      stop_q       <= stop_d;
      load_q       <= load_d;
      data_q       <= data_d;
    end
  end

  assign device_data = data_q;
  assign Run         = run_q;
  assign stop        = stop_q;
  assign load_strobe = load_q;

endmodule
